// File: rtl/reg_bank_inc_pkg.sv
// Shared definitions for the counting register bank: per-cycle operation
// encoding and the command priority decoder.
package reg_bank_inc_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC,
    OP_HOLD
  } op_e;

  // clr beats we beats inc/dec; inc and dec together cancel out
  function automatic op_e decodeOp(input logic clr, input logic we,
                                   input logic inc, input logic dec);
    if (clr)             return OP_CLR;
    else if (we)         return OP_LOAD;
    else if (inc && dec) return OP_HOLD;
    else if (inc)        return OP_INC;
    else if (dec)        return OP_DEC;
    else                 return OP_NONE;
  endfunction

endpackage

// File: rtl/reg_bank_inc_if.sv
// Command/read bus of the counting register bank; master drives commands,
// slave (the bank) returns read data and flags.
interface reg_bank_inc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic                  clr;
  logic                  inc;
  logic                  dec;
  logic [DATA_WIDTH-1:0] step;
  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  zero;
  logic [NUM_REGS-1:0]   ovf;
  logic [NUM_REGS-1:0]   udf;

  modport master (
    output addr, we, clr, inc, dec, step, data_in, rd_addr,
    input  data_out, zero, ovf, udf
  );

  modport slave (
    input  addr, we, clr, inc, dec, step, data_in, rd_addr,
    output data_out, zero, ovf, udf
  );
endinterface

// File: rtl/reg_bank_inc_cell.sv
// One counting register with sticky overflow/underflow flags and
// wrap or saturate arithmetic.
module reg_inc_cell
  import reg_bank_inc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  op_e                   op_i,
  input  logic [DATA_WIDTH-1:0] step_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] value_o,
  output logic                  ovf_o,
  output logic                  udf_o
);

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] diff;
  logic                  borrow;

  assign sum    = {1'b0, value_q} + {1'b0, step_i};
  assign diff   = value_q - step_i;
  assign borrow = step_i > value_q;

  always_comb begin
    value_d = value_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    if (en_i) begin
      unique case (op_i)
        OP_CLR: begin
          value_d = '0;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
        end
        OP_LOAD: begin
          value_d = data_i;
          ovf_d   = 1'b0;
          udf_d   = 1'b0;
        end
        OP_INC: begin
          // a zero step never carries, so it leaves value and flag alone
          if (sum[DATA_WIDTH]) begin
            ovf_d   = 1'b1;
            value_d = (SATURATE != 0) ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
          end else begin
            value_d = sum[DATA_WIDTH-1:0];
          end
        end
        OP_DEC: begin
          if (borrow) begin
            udf_d   = 1'b1;
            value_d = (SATURATE != 0) ? '0 : diff;
          end else begin
            value_d = diff;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign value_o = value_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: rtl/reg_bank_inc.sv
// Bank of NUM_REGS counting registers with a registered read port that
// returns the pre-update value when reading the register being written.
module reg_bank_inc
  import reg_bank_inc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int SATURATE   = 0
) (
  input  logic           clk,
  input  logic           rst,
  reg_bank_inc_if.slave  bus
);

  op_e                   cmdOp;
  logic [DATA_WIDTH-1:0] cellValue [NUM_REGS];
  logic [NUM_REGS-1:0]   ovfVec;
  logic [NUM_REGS-1:0]   udfVec;
  logic [DATA_WIDTH-1:0] readData;
  logic [DATA_WIDTH-1:0] dataOut_q;
  logic                  zero_q;

  assign cmdOp = decodeOp(bus.clr, bus.we, bus.inc, bus.dec);

  // out-of-range addresses match no cell and are therefore ignored
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    reg_inc_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .SATURATE   (SATURATE)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en_i    (bus.addr == ADDR_WIDTH'(i)),
      .op_i    (cmdOp),
      .step_i  (bus.step),
      .data_i  (bus.data_in),
      .value_o (cellValue[i]),
      .ovf_o   (ovfVec[i]),
      .udf_o   (udfVec[i])
    );
  end

  always_comb begin
    readData = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr == ADDR_WIDTH'(i)) readData = cellValue[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut_q <= '0;
      zero_q    <= 1'b1;
    end else begin
      dataOut_q <= readData;
      zero_q    <= (readData == '0);
    end
  end

  assign bus.data_out = dataOut_q;
  assign bus.zero     = zero_q;
  assign bus.ovf      = ovfVec;
  assign bus.udf      = udfVec;

endmodule

// File: tb/tb_reg_bank_inc.sv
// Self-checking bench: a wrapping 4-register bank and a saturating 3-register
// bank driven with identical commands, checked against a behavioural model.
module tb_reg_bank_inc;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_bank_inc_if #(.DATA_WIDTH(8), .NUM_REGS(4), .ADDR_WIDTH(2)) busW ();
  reg_bank_inc_if #(.DATA_WIDTH(8), .NUM_REGS(3), .ADDR_WIDTH(2)) busS ();

  reg_bank_inc #(.DATA_WIDTH(8), .NUM_REGS(4), .ADDR_WIDTH(2), .SATURATE(0)) dutW (
    .clk (clk),
    .rst (rst),
    .bus (busW)
  );

  reg_bank_inc #(.DATA_WIDTH(8), .NUM_REGS(3), .ADDR_WIDTH(2), .SATURATE(1)) dutS (
    .clk (clk),
    .rst (rst),
    .bus (busS)
  );

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic [3:0] ovf;
    logic [3:0] udf;
  } exp_t;

  exp_t expQ [2][$];

  int  mReg [2][4];
  bit  mOvf [2][4];
  bit  mUdf [2][4];
  int  numRegs [2] = '{4, 3};
  int  checks = 0;
  int  errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Model: s=0 wraps, s=1 saturates
  function automatic void modelUpdate(input int s, input bit r, input int a, input bit w,
                                      input bit c, input bit i, input bit d,
                                      input int st, input int din);
    int sum;
    if (r) begin
      for (int k = 0; k < 4; k++) begin
        mReg[s][k] = 0; mOvf[s][k] = 0; mUdf[s][k] = 0;
      end
    end else if (a < numRegs[s]) begin
      if (c) begin
        mReg[s][a] = 0; mOvf[s][a] = 0; mUdf[s][a] = 0;
      end else if (w) begin
        mReg[s][a] = din; mOvf[s][a] = 0; mUdf[s][a] = 0;
      end else if (i && !d) begin
        sum = mReg[s][a] + st;
        if (sum > 255) begin
          mOvf[s][a] = 1;
          mReg[s][a] = (s == 1) ? 255 : sum - 256;
        end else mReg[s][a] = sum;
      end else if (d && !i) begin
        if (st > mReg[s][a]) begin
          mUdf[s][a] = 1;
          mReg[s][a] = (s == 1) ? 0 : mReg[s][a] - st + 256;
        end else mReg[s][a] = mReg[s][a] - st;
      end
    end
  endfunction

  task automatic checkCycle();
    exp_t e;
    if (expQ[0].size() == 0 || expQ[1].size() == 0) begin
      checkOutput("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = expQ[0].pop_front();
    checkOutput("W.data_out", busW.data_out, e.data);
    checkOutput("W.zero", busW.zero, e.zero);
    checkOutput("W.ovf", busW.ovf, e.ovf);
    checkOutput("W.udf", busW.udf, e.udf);
    e = expQ[1].pop_front();
    checkOutput("S.data_out", busS.data_out, e.data);
    checkOutput("S.zero", busS.zero, e.zero);
    checkOutput("S.ovf", {1'b0, busS.ovf}, e.ovf);
    checkOutput("S.udf", {1'b0, busS.udf}, e.udf);
  endtask

  task automatic applyStimulus(input bit r, input int a, input bit w, input bit c,
                               input bit i, input bit d, input int st, input int din,
                               input int ra);
    exp_t e;
    @(negedge clk);
    rst = r;
    busW.addr = 2'(a); busW.we = w; busW.clr = c; busW.inc = i; busW.dec = d;
    busW.step = 8'(st); busW.data_in = 8'(din); busW.rd_addr = 2'(ra);
    busS.addr = 2'(a); busS.we = w; busS.clr = c; busS.inc = i; busS.dec = d;
    busS.step = 8'(st); busS.data_in = 8'(din); busS.rd_addr = 2'(ra);
    for (int s = 0; s < 2; s++) begin
      // read sees the value before this edge's update
      e.data = r ? 8'd0 : ((ra < numRegs[s]) ? 8'(mReg[s][ra]) : 8'd0);
      e.zero = (e.data == 8'd0);
      modelUpdate(s, r, a, w, c, i, d, st, din);
      e.ovf = '0; e.udf = '0;
      for (int k = 0; k < numRegs[s]; k++) begin
        e.ovf[k] = mOvf[s][k]; e.udf[k] = mUdf[s][k];
      end
      expQ[s].push_back(e);
    end
    @(posedge clk);
    #1;
    checkCycle();
  endtask

  initial begin
    rst = 1'b0;
    busW.addr = '0; busW.we = 0; busW.clr = 0; busW.inc = 0; busW.dec = 0;
    busW.step = '0; busW.data_in = '0; busW.rd_addr = '0;
    busS.addr = '0; busS.we = 0; busS.clr = 0; busS.inc = 0; busS.dec = 0;
    busS.step = '0; busS.data_in = '0; busS.rd_addr = '0;

    // reset overrides a simultaneous load
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 8'hAA, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, k);

    // load, increment twice, inc&dec hold
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("W.seq_hold", busW.data_out, 32'd3);

    // wrap vs saturate on reg 2
    applyStimulus(0, 2, 1, 0, 0, 0, 0, 8'hFE, 2);
    applyStimulus(0, 2, 0, 0, 1, 0, 3, 0, 2);
    applyStimulus(0, 2, 0, 0, 0, 1, 2, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2);
    checkOutput("W.wrap_dec", busW.data_out, 32'hFF);
    checkOutput("S.sat_then_dec", busS.data_out, 32'hFD);
    applyStimulus(0, 2, 1, 0, 0, 0, 0, 8'hFE, 2);
    applyStimulus(0, 2, 1, 0, 0, 0, 0, 2, 2);
    applyStimulus(0, 2, 0, 0, 0, 1, 5, 0, 2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2);
    checkOutput("S.sat_zero", busS.data_out, 32'd0);
    checkOutput("W.wrap_udf", busW.data_out, 32'hFD);

    // zero step changes nothing
    applyStimulus(0, 2, 0, 0, 1, 0, 0, 0, 2);
    applyStimulus(0, 2, 0, 0, 0, 1, 0, 0, 2);

    // clr beats we; other registers untouched
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 5, 0);
    applyStimulus(0, 0, 1, 1, 0, 0, 0, 9, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, k);

    // read-before-write on reg 3 (out of range for the 3-register bank)
    applyStimulus(0, 3, 1, 0, 0, 0, 0, 7, 3);
    applyStimulus(0, 3, 0, 0, 1, 0, 1, 0, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3);

    // reset in the middle of an increment burst
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("W.burst_after_rst", busW.data_out, 32'd2);

    // random mix
    for (int n = 0; n < 200; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                    (($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255))),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_inc.md
# reg_bank_inc

Parametrised bank of NUM_REGS up/down counting registers, generalising the single 8-bit load/clear/increment register. Each register supports synchronous load, clear, increment and decrement by a programmable step, with selectable wrap or saturate arithmetic and sticky overflow/underflow flags. A registered read port exposes one register per cycle. Used for address pointers, event counters and loop counters in the datapath.

## Interface
- DATA_WIDTH, 8, width of each register and of data_in, step and data_out
- NUM_REGS, 4, number of registers, ≥2
- ADDR_WIDTH, 2, address width; NUM_REGS ≤ 2**ADDR_WIDTH
- SATURATE, 0, 0 = modulo wrap, 1 = clamp at 0 / 2**DATA_WIDTH-1

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  ADDR_WIDTH  target register for we/clr/inc/dec
- we  in  1  load data_in into regs[addr]
- clr  in  1  clear regs[addr] and its flags
- inc  in  1  regs[addr] += step
- dec  in  1  regs[addr] -= step
- step  in  DATA_WIDTH  increment/decrement amount, unsigned
- data_in  in  DATA_WIDTH  load value
- rd_addr  in  ADDR_WIDTH  read select
- data_out  out  DATA_WIDTH  registered regs[rd_addr]
- zero  out  1  registered, data_out == 0
- ovf  out  NUM_REGS  sticky overflow flag per register
- udf  out  NUM_REGS  sticky underflow flag per register

## Operation
- Per-cycle command priority on regs[addr]: rst > clr > we > inc/dec; only one action per cycle.
- rst: all registers, ovf, udf, data_out = 0; zero = 1.
- clr: regs[addr] = 0, ovf[addr] = udf[addr] = 0.
- we: regs[addr] = data_in; ovf[addr], udf[addr] cleared.
- inc and dec both high (no clr/we): no change, flags unchanged.
- inc: sum computed at DATA_WIDTH+1 bits; carry-out → ovf[addr] = 1. SATURATE=0: result = low DATA_WIDTH bits. SATURATE=1: result = all ones on carry.
- dec: borrow when step > regs[addr] → udf[addr] = 1. SATURATE=0: modulo result. SATURATE=1: result = 0.
- step = 0: register unchanged, no flag set.
- Flags are sticky: set only by the above; cleared only by rst, clr or we on that register.
- addr ≥ NUM_REGS: write-side command ignored. rd_addr ≥ NUM_REGS: data_out = 0.
- Registers not addressed hold value.

## Timing
- Write-side commands take effect at the rising edge where sampled; new value visible in regs next cycle.
- data_out/zero: 1-cycle latency from rd_addr; read-before-write — when rd_addr == addr, data_out shows the pre-update value, updated value one cycle later.
- ovf/udf: driven directly from flag registers, valid the cycle after the causing edge.
- rst mid-operation: overrides any command in the same cycle; no partial update.
- No handshake; commands accepted every cycle, back-to-back inc on the same register accumulates (one step per cycle).

## Structure
- Package reg_bank_inc_pkg: op encoding (OP_NONE, OP_CLR, OP_LOAD, OP_INC, OP_DEC, OP_HOLD for inc&dec) and a priority-decode function from clr/we/inc/dec.
- Sub-module reg_inc_cell: one register plus ovf/udf flops and wrap/saturate arithmetic, parametrised by DATA_WIDTH and SATURATE; instantiated NUM_REGS times via generate, enable = (addr == index).
- Top level: address decode, read mux, data_out/zero output registers.

## Test plan
- Reset: drive rst 1 cycle with we=1, data_in=8'hAA → all registers 0, data_out=0, zero=1, ovf=udf=0.
- Load/inc/hold: addr=1, we, data_in=1; then inc step=1 twice; rd_addr=1 → data_out sequence 1, 2, 3; inc&dec together next → stays 3.
- Wrap (SATURATE=0): load 8'hFE into reg 2, inc step=3 → 8'h01, ovf[2]=1; dec step=2 → 8'hFF, udf[2]=1; we reloads → both flags 0.
- Saturate (SATURATE=1): load 8'hFE, inc step=3 → 8'hFF, ovf set; load 2, dec step=5 → 0, udf set.
- Priority/isolation: clr and we same cycle on reg 0 (data_in=9) → reg 0 = 0; regs 1-3 unchanged; addr=3 inc while rd_addr=3 → data_out shows old value, then new.
- Reset mid-burst: inc every cycle on reg 0 for 5 cycles, rst in cycle 3 → reg 0 = 0 after rst, then counts 1, 2 from resumed incs.
